mem_client: RTL and testbench
=============================

// Module: mem_client
// PURPOSE
//  Initiator side of the put/get word-memory protocol: turns core load/store requests into
//  68-bit {byte_en[3:0], addr[31:0], data[31:0]} memory requests and retires the responses.
//  Sits between the core's load/store stage and the memory; handles byte lanes, sign
//  extension, in-order response tracking and misalignment.
// PARAMETERS
//  MAX_INFLIGHT  2   max requests issued to memory and not yet responded (1..4)
// PORTS
//  CLK               in   1   clock, rising edge
//  RST               in   1   reset, asynchronous, active-high
//  req_valid         in   1   core request valid
//  req_ready         out  1   core request accepted when req_valid && req_ready
//  req_is_store      in   1   1 = store, 0 = load
//  req_size          in   2   0 = byte, 1 = half, 2 = word; 3 is illegal, treated as misaligned
//  req_unsigned      in   1   load zero-extends when 1
//  req_addr          in   32  byte address
//  req_wdata         in   32  store data, LSB-justified
//  resp_valid        out  1   response available to the core
//  resp_ready        in   1   core takes response when resp_valid && resp_ready
//  resp_data         out  32  extended load data; 0 for stores and errors
//  resp_err          out  1   request was misaligned or illegal; never sent to memory
//  mem_put_valid     out  1   request offered to memory
//  mem_put_ready     in   1   memory accepts request
//  mem_put_request   out  68  {byte_en, addr, data}
//  mem_get_valid     out  1   this block consumes a response
//  mem_get_ready     in   1   memory response available
//  mem_get_response  in   68  {byte_en, addr, data}
// BEHAVIOUR
//  - Reset, asynchronous, in any state: resp_valid = 0, resp_err = 0, resp_data = 0.
//    Also clears the inflight count and the metadata FIFO, and drops any requests in flight.
//  - Combinational outputs under RST: req_ready = 0, mem_put_valid = 0, mem_get_valid = 0.
//  - Offset and misalignment:
//      off = req_addr[1:0].
//      Misaligned when size = 1 and off[0] = 1, when size = 2 and off != 0, or when size = 3.
//  - Issue (combinational pass-through, 0-cycle latency):
//      mem_put_valid = req_valid && aligned && cnt < MAX_INFLIGHT && !err_pend.
//      req_ready = mem_put_ready on that path.
//  - Request format:
//      byte_en = 0 for loads; for stores {0001, 0011, 1111}[size] << off.
//      addr = req_addr, unchanged.
//      data = req_wdata << 8*off for stores; 0 for loads.
//  - Metadata FIFO (depth MAX_INFLIGHT):
//      On every put handshake, push {is_store, size, unsigned, off}.
//      cnt increments on put, decrements on get; both in one cycle leaves cnt unchanged.
//  - Response path: one-entry output register.
//      mem_get_valid = (cnt != 0) && (!resp_valid || resp_ready).
//      mem_get_valid must not depend combinationally on mem_put_ready.
//      On a get handshake, pop the FIFO head. Load data: w = rsp.data >> 8*off.
//      Extension: byte -> w[7:0], half -> w[15:0], sign- or zero-extended per unsigned;
//      word -> w.
//      Register the result; resp_valid rises the next cycle (1-cycle response latency).
//      Store responses (data 0) are consumed; resp_data = 0.
//  - Misaligned request:
//      Accepted only when cnt == 0, the output register is free (or draining) and !err_pend.
//      req_ready = 1 in that case; nothing goes to memory.
//      Next cycle: resp_valid = 1, resp_err = 1, resp_data = 0.
//      err_pend blocks further issue until the core takes that response, so order is kept.
//  - Full: cnt == MAX_INFLIGHT -> req_ready = 0 for aligned requests.
//  - Empty: cnt == 0 -> mem_get_valid = 0.
//  - Backpressure: resp_valid held with resp_ready low -> output register and data stable,
//    mem_get_valid = 0.
//  - Simultaneous put and get in one cycle are legal, including with the FIFO full
//    (pop frees the slot next cycle only). Responses return in request order.
// TESTING
//  1) Reset:
//     RST pulse mid-stream with cnt = 2 -> resp_valid 0 at once, cnt 0.
//     Next issued request is handled cleanly.
//  2) Load byte:
//     Load byte signed @0x103 when memory word = 0x80123456 -> put byte_en 0, addr 0x103.
//     resp_data = 0xFFFFFF80 one cycle after the get handshake.
//     Unsigned variant -> resp_data = 0x00000080.
//  3) Store half:
//     Store half @0x102, wdata 0x0000ABCD -> put {0xC, 0x102, 0xABCD0000}.
//     Store response consumed, resp_data = 0.
//     A following word load @0x100 over original word 0x11223344 -> resp_data 0xABCD3344.
//  4) Misaligned:
//     Word load @0x101 -> no mem_put_valid; resp_err = 1, resp_data = 0 next cycle.
//     A pending load is issued only after resp_ready.
//  5) Backpressure:
//     resp_ready = 0 with MAX_INFLIGHT = 2 and 2 loads issued -> req_ready drops to 0.
//     mem_get_valid = 0 while resp_valid is held.
//     Release resp_ready -> both responses delivered in order with correct data.
//  6) Back-to-back stream:
//     8 back-to-back word loads with resp_ready = 1 -> one put per cycle in steady state.
//     Responses arrive in order, none lost or duplicated; cnt never exceeds 2.

Source files
------------

// File: rtl/mem_client.sv
// rtl/mem_client.sv - load/store to put/get word-memory initiator with in-order response retirement
module mem_client #(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_put_valid,
    input  logic        mem_put_ready,
    output logic [67:0] mem_put_request,
    output logic        mem_get_valid,
    input  logic        mem_get_ready,
    input  logic [67:0] mem_get_response
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);
    localparam logic [1:0] LAST_PTR = 2'(MAX_INFLIGHT - 1);

    logic [2:0]  cnt;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [5:0]  meta [4];
    logic [1:0]  off;
    logic        mis, out_free, err_pend, can_issue, mis_ok;
    logic        put_fire, get_fire, mis_fire;
    logic [3:0]  put_be;
    logic [31:0] put_data;
    logic [5:0]  head;
    logic [31:0] shifted, load_val;
    logic        unused_rsp;

    assign unused_rsp = ^mem_get_response[67:32];
    assign off = req_addr[1:0];

    always_comb begin
        mis = 1'b0;
        case (req_size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = (off != 2'd0);
            default: mis = 1'b1;
        endcase
    end

    // An outstanding error response holds back all issue so responses stay in request order.
    assign out_free  = !resp_valid || resp_ready;
    assign err_pend  = resp_valid && resp_err;
    assign can_issue = !mis && (cnt < MAX_CNT) && !err_pend;
    assign mis_ok    = mis && (cnt == 3'd0) && out_free && !err_pend;

    assign mem_put_valid = !RST && req_valid && can_issue;
    assign req_ready     = !RST && (mis ? mis_ok : (can_issue && mem_put_ready));
    assign mem_get_valid = !RST && (cnt != 3'd0) && out_free;

    assign put_fire = mem_put_valid && mem_put_ready;
    assign get_fire = mem_get_valid && mem_get_ready;
    assign mis_fire = req_valid && req_ready && mis;

    always_comb begin
        put_be   = 4'b0000;
        put_data = 32'h0;
        if (req_is_store) begin
            case (req_size)
                2'd0:    put_be = 4'b0001 << off;
                2'd1:    put_be = 4'b0011 << off;
                default: put_be = 4'b1111 << off;
            endcase
            put_data = req_wdata << {off, 3'b000};
        end
    end

    assign mem_put_request = {put_be, req_addr, put_data};

    // head = {is_store, size[1:0], unsigned, off[1:0]} of the oldest request in flight
    assign head    = meta[rd_ptr];
    assign shifted = mem_get_response[31:0] >> {head[1:0], 3'b000};

    always_comb begin
        load_val = shifted;
        case (head[4:3])
            2'd0:    load_val = head[2] ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = head[2] ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
        if (head[5]) begin
            load_val = 32'h0;
        end
    end

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 32'h0;
        end else begin
            if (put_fire) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (get_fire) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({put_fire, get_fire})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            if (get_fire) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= load_val;
            end else if (mis_fire) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_data  <= 32'h0;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (put_fire) begin
            meta[wr_ptr] <= {req_is_store, req_size, req_unsigned, off};
        end
    end

endmodule

// File: tb/tb_mem_client.sv
// tb/tb_mem_client.sv - scoreboard bench for mem_client with a behavioural word memory
module tb_mem_client;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0, req_is_store = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        mem_put_valid, mem_get_valid, mem_get_ready;
    logic        mem_put_ready = 1'b1;
    logic [67:0] mem_put_request, mem_get_response;

    always #5 CLK = ~CLK;

    mem_client #(.MAX_INFLIGHT(2)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_put_valid(mem_put_valid), .mem_put_ready(mem_put_ready),
        .mem_put_request(mem_put_request), .mem_get_valid(mem_get_valid),
        .mem_get_ready(mem_get_ready), .mem_get_response(mem_get_response)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    int          n_cmp = 0, n_fail = 0;
    exp_t        sb [$];
    logic [67:0] rsp_q [$];
    logic [67:0] put_log [$];
    int          put_cyc [$];
    logic [31:0] mem [int];
    logic        have_rsp = 1'b0, got_get = 1'b0;
    logic [67:0] head = 68'h0;
    logic [31:0] wword;
    int          cyc = 0, outstanding = 0, max_out = 0;

    assign mem_get_ready    = have_rsp;
    assign mem_get_response = head;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(int'(a >> 2)) ? mem[int'(a >> 2)] : 32'h0;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic un);
        logic [7:0] b [4];
        logic [7:0] lo, hi;
        int o;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        o = int'(a[1:0]);
        lo = b[o];
        hi = b[(o + 1) % 4];
        case (sz)
            2'd0:    return un ? {24'h0, lo} : {{24{lo[7]}}, lo};
            2'd1:    return un ? {16'h0, hi, lo} : {{16{hi[7]}}, hi, lo};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    // Memory side: one-cycle response latency, stores applied by byte enable at acceptance.
    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        got_get <= 1'b0;
        if (RST) begin
            rsp_q.delete();
            outstanding <= 0;
            have_rsp    <= 1'b0;
            head        <= 68'h0;
        end else begin
            if (mem_get_valid && mem_get_ready) begin
                void'(rsp_q.pop_front());
                got_get <= 1'b1;
            end
            if (mem_put_valid && mem_put_ready) begin
                put_log.push_back(mem_put_request);
                put_cyc.push_back(cyc);
                wword = rd(mem_put_request[63:32]);
                for (int i = 0; i < 4; i++)
                    if (mem_put_request[64+i]) wword[8*i +: 8] = mem_put_request[8*i +: 8];
                if (|mem_put_request[67:64]) begin
                    mem[int'(mem_put_request[63:32] >> 2)] = wword;
                    rsp_q.push_back({mem_put_request[67:32], 32'h0});
                end else begin
                    rsp_q.push_back({mem_put_request[67:32], wword});
                end
            end
            outstanding <= outstanding + ((mem_put_valid && mem_put_ready) ? 1 : 0)
                                       - ((mem_get_valid && mem_get_ready) ? 1 : 0);
            have_rsp <= (rsp_q.size() != 0);
            head     <= (rsp_q.size() != 0) ? rsp_q[0] : 68'h0;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
        end else begin
            if (outstanding > max_out) max_out = outstanding;
            if (got_get) begin
                n_cmp++;
                if (resp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL resp_latency: resp_valid %b want 1 one cycle after get", resp_valid);
                end
            end
            if (resp_valid && resp_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got err %b data %h with nothing expected",
                             resp_err, resp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (resp_err !== e.err || resp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL resp: got err %b data %h want err %b data %h",
                                 resp_err, resp_data, e.err, e.data);
                    end
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic use_model, input logic [31:0] fixed);
        logic        mis;
        logic [31:0] expd;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (req_ready === 1'b1) begin
                expd = (mis || st) ? 32'h0 : (use_model ? model(rd(a), a, sz, un) : fixed);
                n_cmp++;
                if (mem_put_valid !== !mis) begin
                    n_fail++;
                    $display("FAIL put_path: mem_put_valid %b want %b addr %h", mem_put_valid, !mis, a);
                end
                sb.push_back('{err: mis, data: expd});
                @(posedge CLK); #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        n_cmp++; n_fail++;
        $display("FAIL issue_timeout: request addr %h never accepted", a);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (sb.size() == 0 && resp_valid !== 1'b1) begin
                @(posedge CLK); #1;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout: %0d responses still expected", sb.size());
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h0;
        @(negedge CLK);
        n_cmp += 6;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        if (resp_data !== 32'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        if (mem_put_valid !== 1'b0) begin n_fail++; $display("FAIL rst_put_valid: got %b want 0", mem_put_valid); end
        if (mem_get_valid !== 1'b0) begin n_fail++; $display("FAIL rst_get_valid: got %b want 0", mem_get_valid); end
        @(posedge CLK); #1;
        RST = 1'b0; req_valid = 1'b0;
        mem[32'h200 >> 2] = 32'h1111_0001; mem[32'h204 >> 2] = 32'h2222_0002;
        mem[32'h208 >> 2] = 32'h3333_0003; mem[32'h20C >> 2] = 32'h4444_0004;
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h208, 32'h0, 1'b1, 32'h0);
        #2 RST = 1'b1;
        #1;
        n_cmp += 2;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_resp_valid: got %b want 0", resp_valid); end
        if (mem_get_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_get_valid: got %b want 0", mem_get_valid); end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0; resp_ready = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (mem_get_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_cnt: mem_get_valid %b want 0", mem_get_valid); end
        @(posedge CLK); #1;
        issue(1'b0, 2'd2, 1'b0, 32'h20C, 32'h0, 1'b0, 32'h4444_0004);
        wait_idle();
    endtask

    task automatic test_load_byte();
        mem[32'h100 >> 2] = 32'h8012_3456;
        put_log.delete();
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0, 32'h0000_0080);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b0, 32'hFFFF_8012);
        issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 1'b1, 32'h0);
        wait_idle();
        n_cmp++;
        if (put_log.size() < 1 || put_log[0] !== {4'h0, 32'h103, 32'h0}) begin
            n_fail++;
            $display("FAIL load_byte_put: got %h want %h", (put_log.size() > 0) ? put_log[0] : 68'h0,
                     {4'h0, 32'h103, 32'h0});
        end
    endtask

    task automatic test_store_half();
        mem[32'h100 >> 2] = 32'h1122_3344;
        put_log.delete();
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 1'b0, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hABCD_3344);
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_005A, 1'b0, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0000_005A);
        wait_idle();
        n_cmp += 2;
        if (put_log.size() < 3 || put_log[0] !== {4'hC, 32'h102, 32'hABCD_0000}) begin
            n_fail++;
            $display("FAIL store_half_put: got %h want %h", (put_log.size() > 0) ? put_log[0] : 68'h0,
                     {4'hC, 32'h102, 32'hABCD_0000});
        end
        if (put_log.size() < 3 || put_log[2] !== {4'h2, 32'h101, 32'h0000_5A00}) begin
            n_fail++;
            $display("FAIL store_byte_put: got %h want %h", (put_log.size() > 2) ? put_log[2] : 68'h0,
                     {4'h2, 32'h101, 32'h0000_5A00});
        end
    endtask

    task automatic test_misaligned();
        mem[32'h100 >> 2] = 32'hCAFE_F00D;
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0);
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 32'h100;
        for (int t = 0; t < 3; t++) begin
            @(negedge CLK);
            n_cmp++;
            if (mem_put_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL err_blocks_issue: put_valid %b req_ready %b want 0 0", mem_put_valid, req_ready);
            end
            @(posedge CLK); #1;
        end
        resp_ready = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h1234_5678, 1'b1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D);
        wait_idle();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) mem[(32'h300 >> 2) + i] = 32'hA5A5_0000 + 32'(i * 7);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(1'b0, 2'd2, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b1, 32'h0);
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 32'h30C;
        for (int t = 0; t < 4; t++) begin
            @(negedge CLK);
            n_cmp++;
            if (req_ready !== 1'b0 || mem_get_valid !== 1'b0 || resp_valid !== 1'b1 ||
                resp_data !== 32'hA5A5_0000) begin
                n_fail++;
                $display("FAIL backpressure: req_ready %b get_valid %b resp_valid %b data %h want 0 0 1 a5a50000",
                         req_ready, mem_get_valid, resp_valid, resp_data);
            end
            @(posedge CLK); #1;
        end
        resp_ready = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h30C, 32'h0, 1'b0, 32'hA5A5_0015);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[(32'h400 >> 2) + i] = $urandom;
        resp_ready = 1'b1;
        put_cyc.delete();
        max_out = 0;
        for (int i = 0; i < 8; i++)
            issue(1'b0, 2'd2, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 1'b1, 32'h0);
        wait_idle();
        n_cmp += 2;
        if (put_cyc.size() != 8 || put_cyc[7] - put_cyc[0] != 7) begin
            n_fail++;
            $display("FAIL b2b_rate: %0d puts over %0d cycles want 8 over 7", put_cyc.size(),
                     (put_cyc.size() > 0) ? put_cyc[put_cyc.size() - 1] - put_cyc[0] : -1);
        end
        if (max_out > 2) begin
            n_fail++;
            $display("FAIL b2b_inflight: max in flight %0d want <= 2", max_out);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
